// File: rtl/video_pkg.sv
// Shared types and constants for the video scan-out path.
// Holds the reader FSM encoding, AXI encodings and the default raster size.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'h2;
    localparam logic [1:0] AXI_BURST_INCR = 2'h1;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'h0;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'h2;
    localparam logic [2:0] AXI_PROT_NONE  = 3'h0;

    localparam int H_ACTIVE_DEF = 1920;
    localparam int V_ACTIVE_DEF = 1080;

endpackage

// File: rtl/axi_frame_reader_if.sv
// AXI4 read-address/read-data channels plus the AXI4-Stream video output.
// master = the frame reader; slave = memory interconnect and display sink.
interface axi_frame_reader_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [23:0] tdata;
    logic        tuser;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output tdata, tuser, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  tdata, tuser, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/axi_frame_reader_sync_fifo.sv
// Single-clock show-ahead FIFO: pop_dat shows the head entry with zero latency.
// Pushes when full and pops when empty are dropped; simultaneous push/pop keeps occupancy.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);
    // Head is masked while empty so the output bus reads zero out of reset.
    assign pop_dat = (count != '0) ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/axi_frame_reader.sv
// Reads one row-major 32-bit-per-pixel frame from DDR with single outstanding INCR bursts
// and replays it as an AXI4-Stream video stream (tuser = SOF, tlast = EOL).
module axi_frame_reader
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [31:0]               base_addr_i,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic                      rresp_err_o,
    axi_frame_reader_if.master        bus
);
    localparam int TOTAL_BURSTS = H_ACTIVE * V_ACTIVE / BURST_LEN;
    localparam int BW  = (TOTAL_BURSTS > 1) ? $clog2(TOTAL_BURSTS) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CLW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int RWW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int ALIGN = $clog2(BURST_LEN * 4);

    localparam logic [BW-1:0]  LAST_BURST  = BW'(TOTAL_BURSTS - 1);
    localparam logic [31:0]    BURST_BYTES = 32'(BURST_LEN * 4);
    localparam logic [31:0]    ALIGN_MASK  = ~((32'd1 << ALIGN) - 32'd1);
    localparam logic [CW-1:0]  FIFO_SLOTS  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  BURST_SLOTS = CW'(BURST_LEN);
    localparam logic [CLW-1:0] LAST_COL    = CLW'(H_ACTIVE - 1);
    localparam logic [RWW-1:0] LAST_ROW    = RWW'(V_ACTIVE - 1);

    state_t          ctl_sta;
    logic [31:0]     araddr_q;
    logic            arvalid_q;
    logic [BW-1:0]   burst_idx;
    logic            frame_done_q;
    logic            rresp_err_q;
    logic [CW-1:0]   fifo_cnt;
    logic [CLW-1:0]  col;
    logic [RWW-1:0]  row;
    logic            start_acc;
    logic            beat;
    logic            pix_acc;
    logic            room_for_burst;
    logic            unused_rdata;

    assign start_acc      = start_i && (ctl_sta == IDLE);
    assign beat           = bus.rvalid && bus.rready;
    assign pix_acc        = bus.tvalid && bus.tready;
    assign room_for_burst = (FIFO_SLOTS - fifo_cnt) >= BURST_SLOTS;
    assign unused_rdata   = ^bus.rdata[31:24];

    assign bus.araddr  = araddr_q;
    assign bus.arvalid = arvalid_q;
    assign bus.arlen   = 8'(BURST_LEN - 1);
    assign bus.arsize  = AXI_SIZE_4B;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arcache = AXI_CACHE_MOD;
    assign bus.arprot  = AXI_PROT_NONE;
    assign bus.rready  = (ctl_sta == DATA);
    assign bus.tvalid  = (fifo_cnt != '0);
    assign bus.tuser   = bus.tvalid && (col == '0) && (row == '0);
    assign bus.tlast   = bus.tvalid && (col == LAST_COL);

    assign busy_o       = (ctl_sta != IDLE);
    assign frame_done_o = frame_done_q;
    assign rresp_err_o  = rresp_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctl_sta      <= IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            burst_idx    <= '0;
            frame_done_q <= 1'b0;
            rresp_err_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (ctl_sta)
                IDLE: begin
                    if (start_i) begin
                        araddr_q    <= base_addr_i & ALIGN_MASK;
                        rresp_err_q <= 1'b0;
                        burst_idx   <= '0;
                        ctl_sta     <= ADDR;
                    end
                end
                ADDR: begin
                    // Only popping happens here, so reserved room can never shrink once granted.
                    if (arvalid_q && bus.arready) begin
                        arvalid_q <= 1'b0;
                        ctl_sta   <= DATA;
                    end else if (!arvalid_q && room_for_burst) begin
                        arvalid_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (bus.rvalid) begin
                        if (bus.rresp != AXI_RESP_OKAY) rresp_err_q <= 1'b1;
                        if (bus.rlast) begin
                            araddr_q <= araddr_q + BURST_BYTES;
                            if (burst_idx == LAST_BURST) begin
                                ctl_sta <= DRAIN;
                            end else begin
                                burst_idx <= burst_idx + 1'b1;
                                ctl_sta   <= ADDR;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_cnt == '0) begin
                        frame_done_q <= 1'b1;
                        ctl_sta      <= IDLE;
                    end
                end
                default: ctl_sta <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (start_acc) begin
            col <= '0;
            row <= '0;
        end else if (pix_acc) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (beat),
        .push_dat (bus.rdata[23:0]),
        .pop      (pix_acc),
        .pop_dat  (bus.tdata),
        .count    (fifo_cnt)
    );
endmodule
